maze_walker: RTL and testbench

Game-state and player-movement controller that drives the 3-bit level index `count` and the `E_STATE` flag into the map ROM, and consumes the 300-bit collision map `C_map` it returns. It tracks the player cell on the 20×15 grid, blocks moves into walls and off-grid, advances levels on reaching each level's goal cell, and raises a step-count-triggered encounter. Position outputs feed the sprite/VGA drawing logic.

---
 rtl/maze_pkg.sv | 58 +++++
 rtl/maze_walker_if.sv | 22 ++
 rtl/map_probe.sv | 26 ++
 rtl/maze_walker.sv | 161 ++++++++++++++++
 tb/tb_maze_walker.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared types, keycodes, grid size and per-level spawn/goal tables for the
// maze walker.
package maze_pkg;

  localparam int GRID_W = 20;
  localparam int GRID_H = 15;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [2:0] {
    S_TITLE,
    S_LOAD,
    S_PLAY,
    S_ENC,
    S_WIN
  } state_t;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
  } cell_t;

  // Where the player appears when a level is loaded.
  function automatic cell_t spawn_of(input logic [2:0] lvl);
    cell_t c;
    case (lvl)
      3'd1:    c = '{x: 5'd0, y: 4'd2};
      3'd2:    c = '{x: 5'd0, y: 4'd3};
      default: c = '{x: 5'd0, y: 4'd0};
    endcase
    return c;
  endfunction

  // Cell that completes a level.
  function automatic cell_t goal_of(input logic [2:0] lvl);
    cell_t c;
    case (lvl)
      3'd1:    c = '{x: 5'd19, y: 4'd2};
      3'd2:    c = '{x: 5'd2,  y: 4'd13};
      default: c = '{x: 5'd19, y: 4'd14};
    endcase
    return c;
  endfunction

  // Column 0 sits in the MSB of its row, so the bit index runs backwards in x.
  function automatic logic [8:0] cell_bit(input logic [4:0] x, input logic [3:0] y);
    return 9'(y) * 9'd20 + 9'd19 - 9'(x);
  endfunction

  function automatic logic is_dir(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_S) || (k == KEY_A) || (k == KEY_D);
  endfunction

endpackage

// File: rtl/maze_walker_if.sv
// Bundle between the walker and the rest of the game: key/tick/map in,
// level index, encounter flag and player position out.
interface maze_walker_if;
  logic         move_tick;
  logic [7:0]   keycode;
  logic [299:0] C_map;
  logic [2:0]   count;
  logic         E_STATE;
  logic [4:0]   player_x;
  logic [3:0]   player_y;
  logic         level_done;

  modport master (
    output move_tick, keycode, C_map,
    input  count, E_STATE, player_x, player_y, level_done
  );

  modport slave (
    input  move_tick, keycode, C_map,
    output count, E_STATE, player_x, player_y, level_done
  );
endinterface

// File: rtl/map_probe.sv
// Combinational wall/edge test for a candidate target cell. The target comes
// in as signed values so that stepping left from column 0 or up from row 0
// shows up as negative instead of wrapping.
module map_probe
  import maze_pkg::*;
(
  input  logic [299:0]      c_map_i,
  input  logic signed [5:0] tx_i,
  input  logic signed [4:0] ty_i,
  output logic              blocked_o
);

  localparam logic signed [5:0] W_S = 6'(GRID_W);
  localparam logic signed [4:0] H_S = 5'(GRID_H);

  logic       on_grid;
  logic [8:0] idx;

  // Off-grid targets are blocked without looking at the map.
  always_comb begin
    on_grid   = (tx_i >= 6'sd0) && (tx_i < W_S) && (ty_i >= 5'sd0) && (ty_i < H_S);
    idx       = on_grid ? cell_bit(tx_i[4:0], ty_i[3:0]) : 9'd0;
    blocked_o = !on_grid || c_map_i[idx];
  end

endmodule

// File: rtl/maze_walker.sv
// Game-state and player-movement controller: title/level/encounter/win
// sequencing, held-key move pacing, wall-checked movement and step-triggered
// encounters.
module maze_walker
  import maze_pkg::*;
#(
  parameter int MOVE_DIV  = 4,
  parameter int ENC_STEPS = 24
) (
  input logic          Clk,
  input logic          Reset_n,
  maze_walker_if.slave bus
);

  localparam int               DIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(MOVE_DIV - 1);
  localparam logic [4:0]       ENC_LIM  = 5'(ENC_STEPS);

  state_t            state_q;
  logic [2:0]        count_q;
  logic [4:0]        x_q;
  logic [3:0]        y_q;
  logic              enc_q;
  logic              done_q;
  logic [DIV_W-1:0]  div_q, div_d, div_eff;
  logic [4:0]        steps_q, steps_d;
  logic [7:0]        key_prev_q;

  logic              enter_edge;
  logic              dir_held;
  logic              try_move;
  logic              blocked;
  logic              at_goal;
  logic signed [5:0] tx;
  logic signed [4:0] ty;
  cell_t             spawn;
  cell_t             goal;

  assign enter_edge = (bus.keycode == KEY_ENTER) && (key_prev_q != KEY_ENTER);
  assign dir_held   = is_dir(bus.keycode);

  // Hold divider: a new or changed direction key starts from the preload so
  // its first tick moves at once; only PLAY lets it advance.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    div_eff  = (dir_held && (bus.keycode == key_prev_q)) ? div_q : DIV_LOAD;
    div_d    = DIV_LOAD;
    try_move = 1'b0;
    if ((state_q == S_PLAY) && dir_held) begin
      div_d = div_eff;
      if (bus.move_tick) begin
        if (div_eff == DIV_LOAD) begin
          try_move = 1'b1;
          div_d    = '0;
        end else begin
          div_d = div_eff + DIV_W'(1);
        end
      end
    end
  end

  // Candidate cell one step in the held direction, widened to catch -1.
  always_comb begin
    tx = $signed({1'b0, x_q});
    ty = $signed({1'b0, y_q});
    case (bus.keycode)
      KEY_W:   ty = ty - 5'sd1;
      KEY_S:   ty = ty + 5'sd1;
      KEY_A:   tx = tx - 6'sd1;
      KEY_D:   tx = tx + 6'sd1;
      default: ;
    endcase
  end

  map_probe u_probe (
    .c_map_i   (bus.C_map),
    .tx_i      (tx),
    .ty_i      (ty),
    .blocked_o (blocked)
  );

  // Level tables, goal match and the saturating step count.
  always_comb begin
    spawn   = spawn_of(count_q + 3'd1);
    goal    = goal_of(count_q);
    at_goal = (tx[4:0] == goal.x) && (ty[3:0] == goal.y);
    steps_d = (steps_q >= ENC_LIM) ? steps_q : steps_q + 5'd1;
  end

  // Game FSM with all outputs registered alongside the state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_TITLE;
      count_q    <= 3'd0;
      x_q        <= 5'd0;
      y_q        <= 4'd0;
      enc_q      <= 1'b0;
      done_q     <= 1'b0;
      div_q      <= DIV_LOAD;
      steps_q    <= 5'd0;
      key_prev_q <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      key_prev_q <= bus.keycode;
      div_q      <= div_d;
      done_q     <= 1'b0;
      case (state_q)
        S_TITLE: if (enter_edge) state_q <= S_LOAD;
        S_LOAD: begin
          count_q <= count_q + 3'd1;
          x_q     <= spawn.x;
          y_q     <= spawn.y;
          steps_q <= 5'd0;
          state_q <= S_PLAY;
        end
        S_PLAY: begin
          if (try_move && !blocked) begin
            x_q     <= tx[4:0];
            y_q     <= ty[3:0];
            steps_q <= steps_d;
            if (at_goal) begin
              done_q <= 1'b1;
              if (count_q < 3'd3) begin
                state_q <= S_LOAD;
              end else begin
                state_q <= S_WIN;
                count_q <= 3'd4;
              end
            end else if (steps_d == ENC_LIM) begin
              state_q <= S_ENC;
              enc_q   <= 1'b1;
            end
          end
        end
        S_ENC: begin
          if (enter_edge) begin
            state_q <= S_PLAY;
            enc_q   <= 1'b0;
            steps_q <= 5'd0;
          end
        end
        S_WIN: begin
          if (enter_edge) begin
            state_q <= S_TITLE;
            count_q <= 3'd0;
          end
        end
        default: state_q <= S_TITLE;
      endcase
    end
  end

  assign bus.count      = count_q;
  assign bus.E_STATE    = enc_q;
  assign bus.player_x   = x_q;
  assign bus.player_y   = y_q;
  assign bus.level_done = done_q;

endmodule

// File: tb/tb_maze_walker.sv
// Bench for maze_walker: a cycle model of the game pushes the expected
// outputs for every driven cycle into a queue, which is popped and compared
// on the following falling edge; scenario tasks add directed spot checks.
module tb_maze_walker;

  localparam int MOVE_DIV  = 4;
  localparam int ENC_STEPS = 3;

  localparam logic [7:0] K_NONE  = 8'h00;
  localparam logic [7:0] K_W     = 8'h1A;
  localparam logic [7:0] K_S     = 8'h16;
  localparam logic [7:0] K_A     = 8'h04;
  localparam logic [7:0] K_D     = 8'h07;
  localparam logic [7:0] K_ENTER = 8'h28;

  localparam int ST_TITLE = 0, ST_LOAD = 1, ST_PLAY = 2, ST_ENC = 3, ST_WIN = 4;

  typedef struct packed {
    logic [2:0] count;
    logic       e;
    logic [4:0] x;
    logic [3:0] y;
    logic       done;
  } obs_t;

  logic Clk;
  logic Reset_n;

  maze_walker_if bus ();

  maze_walker #(
    .MOVE_DIV  (MOVE_DIV),
    .ENC_STEPS (ENC_STEPS)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cycle  = 0;

  obs_t exp_q[$];

  // Model state
  int         m_st, m_count, m_x, m_y, m_steps, m_div;
  logic       m_e;
  logic [7:0] m_prev;

  function automatic int wall_bit(input int x, input int y);
    return 20 * y + 19 - x;
  endfunction

  // Map ROM: combinational on the level index.
  function automatic logic [299:0] rom(input logic [2:0] lvl);
    logic [299:0] m;
    m = '0;
    case (lvl)
      3'd1: begin
        m[wall_bit(0, 1)] = 1'b1;
        m[wall_bit(4, 2)] = 1'b1;
      end
      3'd2: m[wall_bit(1, 3)] = 1'b1;
      3'd3: m[wall_bit(5, 5)] = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  always_comb bus.C_map = rom(bus.count);

  function automatic int goal_x(input int lvl);
    return (lvl == 2) ? 2 : 19;
  endfunction

  function automatic int goal_y(input int lvl);
    return (lvl == 1) ? 2 : (lvl == 2) ? 13 : 14;
  endfunction

  function automatic int spawn_y(input int lvl);
    return (lvl == 1) ? 2 : (lvl == 2) ? 3 : 0;
  endfunction

  task automatic model_reset();
    m_st    = ST_TITLE;
    m_count = 0;
    m_x     = 0;
    m_y     = 0;
    m_steps = 0;
    m_div   = MOVE_DIV - 1;
    m_e     = 1'b0;
    m_prev  = K_NONE;
    exp_q.delete();
  endtask

  // Drive one clock cycle, predict its outcome, then check it.
  task automatic cycle(input logic [7:0] key, input logic tick);
    int           dx, dy, nx, ny;
    bit           is_dir, enter_edge, attempt, blk;
    logic [299:0] mp;
    obs_t         o_exp, o_act;

    bus.keycode   = key;
    bus.move_tick = tick;

    enter_edge = (key == K_ENTER) && (m_prev != K_ENTER);
    dx = 0; dy = 0; is_dir = 1'b1;
    case (key)
      K_W:     dy = -1;
      K_S:     dy = 1;
      K_A:     dx = -1;
      K_D:     dx = 1;
      default: is_dir = 1'b0;
    endcase
    attempt    = 1'b0;
    o_exp.done = 1'b0;

    case (m_st)
      ST_TITLE: begin
        m_div = MOVE_DIV - 1;
        if (enter_edge) m_st = ST_LOAD;
      end
      ST_LOAD: begin
        m_div   = MOVE_DIV - 1;
        m_count = m_count + 1;
        m_x     = 0;
        m_y     = spawn_y(m_count);
        m_steps = 0;
        m_st    = ST_PLAY;
      end
      ST_PLAY: begin
        if (!is_dir) begin
          m_div = MOVE_DIV - 1;
        end else begin
          if (key != m_prev) m_div = MOVE_DIV - 1;
          if (tick) begin
            attempt = (m_div == MOVE_DIV - 1);
            m_div   = attempt ? 0 : m_div + 1;
          end
        end
        if (attempt) begin
          nx  = m_x + dx;
          ny  = m_y + dy;
          mp  = rom(3'(m_count));
          blk = (nx < 0) || (nx > 19) || (ny < 0) || (ny > 14);
          if (!blk) blk = mp[wall_bit(nx, ny)];
          if (!blk) begin
            m_x = nx;
            m_y = ny;
            if (m_steps < ENC_STEPS) m_steps = m_steps + 1;
            if ((nx == goal_x(m_count)) && (ny == goal_y(m_count))) begin
              o_exp.done = 1'b1;
              if (m_count < 3) begin
                m_st = ST_LOAD;
              end else begin
                m_st    = ST_WIN;
                m_count = 4;
              end
            end else if (m_steps == ENC_STEPS) begin
              m_st = ST_ENC;
              m_e  = 1'b1;
            end
          end
        end
      end
      ST_ENC: begin
        m_div = MOVE_DIV - 1;
        if (enter_edge) begin
          m_st    = ST_PLAY;
          m_e     = 1'b0;
          m_steps = 0;
        end
      end
      default: begin
        m_div = MOVE_DIV - 1;
        if (enter_edge) begin
          m_st    = ST_TITLE;
          m_count = 0;
        end
      end
    endcase
    m_prev = key;

    o_exp.count = 3'(m_count);
    o_exp.e     = m_e;
    o_exp.x     = 5'(m_x);
    o_exp.y     = 4'(m_y);
    exp_q.push_back(o_exp);

    @(posedge Clk);
    @(negedge Clk);
    n_cycle++;

    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_empty cycle %0d: no expected entry queued", n_cycle);
    end else begin
      o_exp = exp_q.pop_front();
      o_act = {bus.count, bus.E_STATE, bus.player_x, bus.player_y, bus.level_done};
      if (o_act !== o_exp)
        $display("FAIL sb cycle %0d: got count=%0d e=%0b xy=(%0d,%0d) done=%0b, want count=%0d e=%0b xy=(%0d,%0d) done=%0b",
                 n_cycle, o_act.count, o_act.e, o_act.x, o_act.y, o_act.done,
                 o_exp.count, o_exp.e, o_exp.x, o_exp.y, o_exp.done);
      else
        n_pass++;
    end
  endtask

  task automatic tap(input logic [7:0] k);
    cycle(k, 1'b1);
    cycle(K_NONE, 1'b0);
  endtask

  task automatic press_enter();
    cycle(K_ENTER, 1'b0);
    cycle(K_NONE, 1'b0);
  endtask

  // Repeated single steps, dismissing any encounter on the way.
  task automatic walk(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      tap(k);
      if (m_st == ST_ENC) press_enter();
    end
  endtask

  task automatic test_reset();
    Reset_n       = 1'b0;
    bus.keycode   = K_NONE;
    bus.move_tick = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({bus.count, bus.E_STATE, bus.player_x, bus.player_y, bus.level_done} !== 14'd0)
      $display("FAIL reset_values: got count=%0d e=%0b xy=(%0d,%0d) done=%0b, want all 0",
               bus.count, bus.E_STATE, bus.player_x, bus.player_y, bus.level_done);
    else n_pass++;
    Reset_n = 1'b1;
    model_reset();
    cycle(K_NONE, 1'b0);
    cycle(K_D, 1'b1);
    cycle(K_NONE, 1'b0);
  endtask

  task automatic test_start();
    press_enter();
    n_checks++;
    if ({bus.count, bus.E_STATE, bus.player_x, bus.player_y} !== {3'd1, 1'b0, 5'd0, 4'd2})
      $display("FAIL start_l1: got count=%0d e=%0b xy=(%0d,%0d), want count=1 e=0 xy=(0,2)",
               bus.count, bus.E_STATE, bus.player_x, bus.player_y);
    else n_pass++;
    press_enter();
  endtask

  task automatic test_blocked();
    tap(K_W);
    tap(K_A);
    n_checks++;
    if ({bus.player_x, bus.player_y} !== {5'd0, 4'd2})
      $display("FAIL blocked_l1: got xy=(%0d,%0d), want (0,2)", bus.player_x, bus.player_y);
    else n_pass++;
  endtask

  task automatic test_hold_divider();
    repeat (4) cycle(K_D, 1'b1);
    n_checks++;
    if (bus.player_x !== 5'd1)
      $display("FAIL hold_4_ticks: got x=%0d, want 1", bus.player_x);
    else n_pass++;
    cycle(K_D, 1'b1);
    n_checks++;
    if (bus.player_x !== 5'd2)
      $display("FAIL hold_5th_tick: got x=%0d, want 2", bus.player_x);
    else n_pass++;
    cycle(K_NONE, 1'b0);
  endtask

  task automatic test_level1_enc_and_wall();
    tap(K_D);
    n_checks++;
    if ({bus.E_STATE, bus.player_x} !== {1'b1, 5'd3})
      $display("FAIL enc_l1: got e=%0b x=%0d, want e=1 x=3", bus.E_STATE, bus.player_x);
    else n_pass++;
    tap(K_S);
    n_checks++;
    if ({bus.E_STATE, bus.player_x, bus.player_y} !== {1'b1, 5'd3, 4'd2})
      $display("FAIL enc_frozen: got e=%0b xy=(%0d,%0d), want e=1 xy=(3,2)",
               bus.E_STATE, bus.player_x, bus.player_y);
    else n_pass++;
    press_enter();
    n_checks++;
    if (bus.E_STATE !== 1'b0)
      $display("FAIL enc_clear: got e=%0b, want 0", bus.E_STATE);
    else n_pass++;
    tap(K_D);
    n_checks++;
    if ({bus.player_x, bus.player_y} !== {5'd3, 4'd2})
      $display("FAIL wall_col4: got xy=(%0d,%0d), want (3,2)", bus.player_x, bus.player_y);
    else n_pass++;
  endtask

  task automatic test_dir_change();
    tap(K_S);
    cycle(K_D, 1'b1);
    n_checks++;
    if ({bus.E_STATE, bus.player_x, bus.player_y} !== {1'b0, 5'd4, 4'd3})
      $display("FAIL wall_no_step: got e=%0b xy=(%0d,%0d), want e=0 xy=(4,3)",
               bus.E_STATE, bus.player_x, bus.player_y);
    else n_pass++;
    cycle(K_A, 1'b1);
    n_checks++;
    if ({bus.E_STATE, bus.player_x} !== {1'b1, 5'd3})
      $display("FAIL dir_change_reload: got e=%0b x=%0d, want e=1 x=3", bus.E_STATE, bus.player_x);
    else n_pass++;
    cycle(K_NONE, 1'b0);
    press_enter();
  endtask

  task automatic test_level1_goal();
    walk(K_D, 16);
    cycle(K_W, 1'b1);
    n_checks++;
    if ({bus.level_done, bus.count} !== {1'b1, 3'd1})
      $display("FAIL goal_l1_pulse: got done=%0b count=%0d, want done=1 count=1",
               bus.level_done, bus.count);
    else n_pass++;
    cycle(K_NONE, 1'b0);
    n_checks++;
    if ({bus.level_done, bus.count, bus.player_x, bus.player_y} !== {1'b0, 3'd2, 5'd0, 4'd3})
      $display("FAIL load_l2: got done=%0b count=%0d xy=(%0d,%0d), want done=0 count=2 xy=(0,3)",
               bus.level_done, bus.count, bus.player_x, bus.player_y);
    else n_pass++;
  endtask

  task automatic test_reset_mid_level2();
    tap(K_D);
    n_checks++;
    if ({bus.player_x, bus.player_y} !== {5'd0, 4'd3})
      $display("FAIL wall_l2: got xy=(%0d,%0d), want (0,3)", bus.player_x, bus.player_y);
    else n_pass++;
    cycle(K_S, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.count, bus.E_STATE, bus.player_x, bus.player_y, bus.level_done} !== 14'd0)
      $display("FAIL async_reset: got count=%0d e=%0b xy=(%0d,%0d) done=%0b, want all 0",
               bus.count, bus.E_STATE, bus.player_x, bus.player_y, bus.level_done);
    else n_pass++;
    bus.keycode   = K_NONE;
    bus.move_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      n_checks++;
      if ({bus.level_done, bus.count} !== 4'd0)
        $display("FAIL reset_hold %0d: got done=%0b count=%0d, want 0/0", i, bus.level_done, bus.count);
      else n_pass++;
    end
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_replay_to_level3();
    press_enter();
    walk(K_D, 3);
    walk(K_S, 1);
    walk(K_D, 16);
    walk(K_W, 1);
    walk(K_S, 10);
    walk(K_D, 2);
    n_checks++;
    if ({bus.count, bus.player_x, bus.player_y} !== {3'd3, 5'd0, 4'd0})
      $display("FAIL reach_l3: got count=%0d xy=(%0d,%0d), want count=3 xy=(0,0)",
               bus.count, bus.player_x, bus.player_y);
    else n_pass++;
  endtask

  task automatic test_level3_enc();
    tap(K_W);
    tap(K_A);
    n_checks++;
    if ({bus.player_x, bus.player_y} !== {5'd0, 4'd0})
      $display("FAIL offgrid_l3: got xy=(%0d,%0d), want (0,0)", bus.player_x, bus.player_y);
    else n_pass++;
    for (int round = 0; round < 2; round++) begin
      tap(K_D);
      tap(K_D);
      cycle(K_D, 1'b1);
      n_checks++;
      if (bus.E_STATE !== 1'b1)
        $display("FAIL enc_l3 round %0d: got e=%0b, want 1", round, bus.E_STATE);
      else n_pass++;
      cycle(K_NONE, 1'b0);
      tap(K_S);
      n_checks++;
      if ({bus.player_x, bus.player_y} !== {5'(3 * round + 3), 4'd0})
        $display("FAIL enc_l3_frozen round %0d: got xy=(%0d,%0d), want (%0d,0)",
                 round, bus.player_x, bus.player_y, 3 * round + 3);
      else n_pass++;
      press_enter();
      n_checks++;
      if (bus.E_STATE !== 1'b0)
        $display("FAIL enc_l3_clear round %0d: got e=%0b, want 0", round, bus.E_STATE);
      else n_pass++;
    end
  endtask

  task automatic test_win_and_title();
    walk(K_D, 13);
    walk(K_S, 13);
    cycle(K_S, 1'b1);
    n_checks++;
    if ({bus.level_done, bus.count, bus.E_STATE} !== {1'b1, 3'd4, 1'b0})
      $display("FAIL win_pulse: got done=%0b count=%0d e=%0b, want done=1 count=4 e=0",
               bus.level_done, bus.count, bus.E_STATE);
    else n_pass++;
    cycle(K_NONE, 1'b0);
    n_checks++;
    if ({bus.level_done, bus.count} !== {1'b0, 3'd4})
      $display("FAIL win_hold: got done=%0b count=%0d, want done=0 count=4", bus.level_done, bus.count);
    else n_pass++;
    press_enter();
    n_checks++;
    if (bus.count !== 3'd0)
      $display("FAIL back_to_title: got count=%0d, want 0", bus.count);
    else n_pass++;
    cycle(K_ENTER, 1'b0);
    repeat (3) cycle(K_ENTER, 1'b0);
    cycle(K_NONE, 1'b0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_blocked();
    test_hold_divider();
    test_level1_enc_and_wall();
    test_dir_change();
    test_level1_goal();
    test_reset_mid_level2();
    test_replay_to_level3();
    test_level3_enc();
    test_win_and_title();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
